uart_cmd_parser: RTL

Consumes received bytes from the UART RX FIFO read port and decodes ASCII command frames of the form `$<letter>[<hex><hex>]<CR>` into a one-cycle command strobe with an 8-bit letter code and an optional 8-bit argument. It sits directly downstream of the UART receive FIFO, in place of the loopback path, and feeds the application control logic. Malformed frames, receiver framing errors and inter-byte timeouts are reported on a separate error strobe.

---
 rtl/uart_cmd_parser.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// ASCII command-frame decoder ($<letter>[<hex><hex>]<CR>) fed from the UART RX FIFO.
// Define UART_CMD_ECHO_EN to echo every popped byte into the TX FIFO.
module uart_cmd_parser #(
  parameter int unsigned DATA_W      = 9,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_pop,
  input  logic              tx_full,
  output logic              tx_push,
  output logic [DATA_W-1:0] tx_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd_code,
  output logic [7:0]        cmd_arg,
  output logic              cmd_has_arg,
  output logic              cmd_err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {StIdle, StCmd, StArgHi, StArgLo, StEnd} state_e;

  localparam logic [7:0]  ChDollar = 8'h24;
  localparam logic [7:0]  ChCr     = 8'h0d;
  localparam logic [23:0] TmoLast  = 24'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ErrBad   = 2'd0;
  localparam logic [1:0] ErrFrame = 2'd1;
  localparam logic [1:0] ErrTmo   = 2'd2;
  localparam logic [1:0] ErrSync  = 2'd3;

  state_e      state_q;
  logic [23:0] tmo_cnt_q;
  logic [7:0]  letter_q;
  logic [3:0]  hi_q;
  logic [3:0]  lo_q;

  logic [7:0] rx_byte;
  logic       rx_ferr;
  logic       is_letter;
  logic       hex_ok;
  logic [3:0] hex_val;
  logic       unused_ok;

`ifdef UART_CMD_ECHO_EN
  assign rx_pop  = !rx_empty && !tx_full;
  assign tx_push = rx_pop;
  assign tx_data = {{(DATA_W-8){1'b0}}, rx_data[7:0]};
`else
  assign rx_pop  = !rx_empty;
  assign tx_push = 1'b0;
  assign tx_data = '0;
`endif

  assign unused_ok = ^{tx_full, rx_data};

  assign rx_byte   = rx_data[7:0];
  assign rx_ferr   = rx_data[8];
  assign is_letter = (rx_byte >= 8'h41) && (rx_byte <= 8'h5a);

  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
      hex_val = rx_byte[3:0];
    end else if ((rx_byte >= 8'h41 && rx_byte <= 8'h46) ||
                 (rx_byte >= 8'h61 && rx_byte <= 8'h66)) begin
      hex_val = rx_byte[3:0] + 4'd9;
    end else begin
      hex_ok = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      tmo_cnt_q   <= '0;
      letter_q    <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_arg     <= '0;
      cmd_has_arg <= 1'b0;
      cmd_err     <= 1'b0;
      err_code    <= '0;
    end else begin
      cmd_valid <= 1'b0;
      cmd_err   <= 1'b0;
      if (rx_pop) begin
        tmo_cnt_q <= '0;
        if (state_q != StIdle && rx_ferr) begin
          cmd_err  <= 1'b1;
          err_code <= ErrFrame;
          state_q  <= StIdle;
        end else begin
          unique case (state_q)
            StIdle: begin
              if (!rx_ferr && rx_byte == ChDollar) state_q <= StCmd;
            end
            StCmd: begin
              if (is_letter) begin
                letter_q <= rx_byte;
                state_q  <= StArgHi;
              end else if (rx_byte == ChDollar) begin
                cmd_err  <= 1'b1;
                err_code <= ErrSync;
              end else begin
                cmd_err  <= 1'b1;
                err_code <= ErrBad;
                state_q  <= StIdle;
              end
            end
            StArgHi, StArgLo, StEnd: begin
              if (state_q == StArgHi && rx_byte == ChCr) begin
                cmd_valid   <= 1'b1;
                cmd_code    <= letter_q;
                cmd_arg     <= 8'h00;
                cmd_has_arg <= 1'b0;
                state_q     <= StIdle;
              end else if (state_q == StArgHi && hex_ok) begin
                hi_q    <= hex_val;
                state_q <= StArgLo;
              end else if (state_q == StArgLo && hex_ok) begin
                lo_q    <= hex_val;
                state_q <= StEnd;
              end else if (state_q == StEnd && rx_byte == ChCr) begin
                cmd_valid   <= 1'b1;
                cmd_code    <= letter_q;
                cmd_arg     <= {hi_q, lo_q};
                cmd_has_arg <= 1'b1;
                state_q     <= StIdle;
              end else if (rx_byte == ChDollar) begin
                cmd_err  <= 1'b1;
                err_code <= ErrSync;
                state_q  <= StCmd;
              end else begin
                cmd_err  <= 1'b1;
                err_code <= ErrBad;
                state_q  <= StIdle;
              end
            end
            default: state_q <= StIdle;
          endcase
        end
      end else if (state_q == StIdle) begin
        tmo_cnt_q <= '0;
      end else if (tmo_cnt_q >= TmoLast) begin
        cmd_err   <= 1'b1;
        err_code  <= ErrTmo;
        state_q   <= StIdle;
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 24'd1;
      end
    end
  end

endmodule
